// File: rtl/round_robin_arbiter_hold.sv
// ----------------------------------------------------------------------------
// round_robin_arbiter_hold
//
// Registered round-robin arbiter with grant hold and bounded tenure.
// The current owner keeps the grant while its request stays high. Once it has
// held for HOLD_MAX cycles and another requester is waiting, the grant is
// forcibly rotated to the next requester. Rotation starts just above the
// last winner, so every requester is eventually served.
//
// Parameters
//   WORD_WIDTH  number of requesters (bit 0 wins first after reset)
//   HOLD_MAX    max consecutive grant cycles while others wait; 0 = unlimited
//   HOLD_WIDTH  tenure counter width, must be able to hold HOLD_MAX
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   requests     in   [WORD_WIDTH-1:0] level-sensitive request bits
//   grant        out  [WORD_WIDTH-1:0] registered one-hot grant, or zero
//   grant_valid  out  registered, high when grant != 0
//   preempted    out  registered one-cycle pulse when the grant is rotated
//                     away from an owner that still requests
// ----------------------------------------------------------------------------
module round_robin_arbiter_hold #(
   parameter int WORD_WIDTH = 4,
   parameter int HOLD_MAX   = 8,
   parameter int HOLD_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WORD_WIDTH-1:0] requests,
   output logic [WORD_WIDTH-1:0] grant,
   output logic                  grant_valid,
   output logic                  preempted
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [WORD_WIDTH-1:0] WORD_ONE = WORD_WIDTH'(1);
   // Reset value of last: the top bit, so the first rotation wraps to bit 0.
   localparam logic [WORD_WIDTH-1:0] LAST_RST = WORD_ONE << (WORD_WIDTH - 1);
   localparam logic [HOLD_WIDTH-1:0] HOLD_LIM = HOLD_WIDTH'(HOLD_MAX);
   localparam logic [HOLD_WIDTH-1:0] COUNT_ONE = HOLD_WIDTH'(1);

   state_t                  state, state_nxt;
   logic [WORD_WIDTH-1:0]   last, last_nxt;
   logic [WORD_WIDTH-1:0]   grant_nxt;
   logic [HOLD_WIDTH-1:0]   count, count_nxt;
   logic                    preempted_nxt;
   logic [WORD_WIDTH-1:0]   others;

   // Round-robin pick: lowest request strictly above lst, else lowest overall.
   // (lst << 1) - 1 is a mask of lst and everything below it; when lst is the
   // top bit the shift overflows to 0 and the mask becomes all ones, so
   // "above" is empty and the pick wraps to the lowest set bit.
   function automatic logic [WORD_WIDTH-1:0] pick(
      input logic [WORD_WIDTH-1:0] req,
      input logic [WORD_WIDTH-1:0] lst
   );
      logic [WORD_WIDTH-1:0] above;
      above = req & ~((lst << 1) - WORD_ONE);
      if (above != '0) begin
         pick = above & (-above);
      end else begin
         pick = req & (-req);
      end
   endfunction

   assign others = requests & ~grant;

   // NOTE: every variable driven here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      last_nxt      = last;
      count_nxt     = count;
      preempted_nxt = 1'b0;

      if (state == IDLE) begin
         if (requests != '0) begin
            grant_nxt = pick(requests, last);
            last_nxt  = grant_nxt;
            count_nxt = COUNT_ONE;
            state_nxt = BUSY;
         end else begin
            grant_nxt = '0;
         end
      end else begin
         if ((requests & grant) == '0) begin
            // Owner released: hand over directly, no idle bubble.
            grant_nxt = pick(requests, last);
            count_nxt = COUNT_ONE;
            if (requests == '0) begin
               state_nxt = IDLE;
            end else begin
               last_nxt = grant_nxt;
            end
         end else if ((HOLD_MAX != 0) && (count >= HOLD_LIM) && (others != '0)) begin
            // Tenure exhausted with others waiting: rotate away from owner.
            grant_nxt     = pick(others, last);
            last_nxt      = grant_nxt;
            count_nxt     = COUNT_ONE;
            preempted_nxt = 1'b1;
         end else if (count < HOLD_LIM) begin
            count_nxt = count + COUNT_ONE;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         preempted   <= 1'b0;
         last        <= LAST_RST;
         count       <= '0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         grant_valid <= (grant_nxt != '0);
         preempted   <= preempted_nxt;
         last        <= last_nxt;
         count       <= count_nxt;
      end
   end

endmodule

// File: tb/tb_round_robin_arbiter_hold.sv
// ----------------------------------------------------------------------------
// tb_round_robin_arbiter_hold
//
// Self-checking bench for round_robin_arbiter_hold (WORD_WIDTH=4, HOLD_MAX=3).
// A behavioural model tracks the owner as an index and rotates by scanning
// requesters cyclically from the last winner. A negedge process compares the
// DUT to the model every cycle and checks one-hot, grant-within-requests and
// a starvation bound. Directed sequences add hand-computed literal checks,
// followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_round_robin_arbiter_hold;

   localparam int W  = 4;
   localparam int HM = 3;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] requests = '0;
   logic [W-1:0] grant;
   logic         grant_valid;
   logic         preempted;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   round_robin_arbiter_hold #(
      .WORD_WIDTH (W),
      .HOLD_MAX   (HM),
      .HOLD_WIDTH (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .requests    (requests),
      .grant       (grant),
      .grant_valid (grant_valid),
      .preempted   (preempted)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------ model
   typedef struct {
      int owner;   // granted requester index, -1 when nothing is granted
      int last;    // index of the most recent winner
      int count;   // cycles the owner has held
      bit pre;     // grant was rotated away from a still-requesting owner
   } model_t;

   localparam model_t MODEL_RST = '{owner: -1, last: W - 1, count: 0, pre: 1'b0};

   model_t       m        = MODEL_RST;
   logic [W-1:0] prev_req = '0;
   int           waits[W] = '{default: 0};

   // First set requester met walking upward (with wrap) from just after last.
   function automatic int rr_pick(input logic [W-1:0] r, input int last);
      for (int k = 1; k <= W; k++) begin
         int idx = (last + k) % W;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic model_t model_next(input model_t s, input logic [W-1:0] r);
      model_t       n;
      int           p;
      logic [W-1:0] others;
      n     = s;
      n.pre = 1'b0;
      if (s.owner < 0) begin
         p = rr_pick(r, s.last);
         if (p >= 0) begin
            n.owner = p;
            n.last  = p;
            n.count = 1;
         end
      end else if (!r[s.owner]) begin
         p       = rr_pick(r, s.last);
         n.owner = p;
         n.count = 1;
         if (p >= 0) n.last = p;
      end else begin
         others          = r;
         others[s.owner] = 1'b0;
         if (s.count >= HM && others != '0) begin
            p       = rr_pick(others, s.last);
            n.owner = p;
            n.last  = p;
            n.count = 1;
            n.pre   = 1'b1;
         end else if (s.count < HM) begin
            n.count = s.count + 1;
         end
      end
      return n;
   endfunction

   function automatic logic [W-1:0] owner_vec(input int o);
      logic [W-1:0] v;
      v = '0;
      if (o >= 0) v[o] = 1'b1;
      return v;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m        <= MODEL_RST;
         prev_req <= '0;
      end else begin
         m        <= model_next(m, requests);
         prev_req <= requests;
      end
   end

   // ---------------------------------------------------------------- compare
   always @(negedge clock) begin
      check("grant_vs_model", grant, owner_vec(m.owner));
      check("valid_vs_model", grant_valid, (m.owner >= 0));
      check("preempt_vs_model", preempted, m.pre);
      check("onehot", $onehot0(grant), 1);
      check("grant_in_requests", grant & ~prev_req, 0);
      for (int i = 0; i < W; i++) begin
         check("starvation_bound", (waits[i] <= 3 * HM), 1);
      end
      for (int i = 0; i < W; i++) begin
         if (reset) waits[i] <= 0;
         else if (prev_req[i] && !grant[i]) waits[i] <= waits[i] + 1;
         else waits[i] <= 0;
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic step(input logic [W-1:0] r);
      requests = r;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      requests = '0;
      reset    = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [W-1:0] r;

      // 1. Reset with all requests high, then first grant goes to bit 0.
      #1;
      reset    = 1'b1;
      requests = 4'b1111;
      #12;
      check("t1_reset_grant", grant, 4'b0000);
      check("t1_reset_valid", grant_valid, 0);
      check("t1_reset_pre", preempted, 0);
      reset = 1'b0;
      step(4'b1111);
      check("t1_first_grant", grant, 4'b0001);

      // 2. 0101 -> 0001, then owner drops -> 0100 without pre-emption.
      do_reset();
      step(4'b0101);
      check("t2_grant0", grant, 4'b0001);
      step(4'b0100);
      check("t2_grant2", grant, 4'b0100);
      check("t2_no_pre", preempted, 0);

      // 3. All requesting: three cycles each, pulse on each forced switch.
      do_reset();
      for (int c = 0; c < 13; c++) begin
         step(4'b1111);
         check("t3_rotate_grant", grant, owner_vec((c / 3) % W));
         check("t3_rotate_pre", preempted, (c > 0 && c % 3 == 0));
      end

      // 4. Lone requester holds indefinitely, then release goes idle.
      for (int c = 0; c < 10; c++) begin
         step(4'b0010);
         check("t4_lone_grant", grant, 4'b0010);
         check("t4_lone_pre", preempted, 0);
      end
      step(4'b0000);
      check("t4_idle_grant", grant, 4'b0000);
      check("t4_idle_valid", grant_valid, 0);

      // 5. Reset in the middle of a grant clears it without waiting for an edge.
      step(4'b0100);
      check("t5_grant2", grant, 4'b0100);
      step(4'b0100);
      #2;
      reset = 1'b1;
      #1;
      check("t5_async_grant", grant, 4'b0000);
      check("t5_async_valid", grant_valid, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      step(4'b1100);
      check("t5_after_reset", grant, 4'b0100);

      // 6. Owner drops while others request: direct handover, no zero cycle.
      step(4'b0000);
      step(4'b0001);
      check("t6_owner0", grant, 4'b0001);
      step(4'b1010);
      check("t6_handover", grant, 4'b0010);
      check("t6_handover_valid", grant_valid, 1);

      // Randomized run: sticky requests that toggle occasionally.
      r = 4'b0000;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
         end
         step(r);
      end

      @(negedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
